// File: rtl/imm_pkg.sv
// Shared types for the pipelined immediate generator: format select encoding
// and fixed instruction-side widths.
package imm_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned SRC_W   = 3;

  typedef enum logic [SRC_W-1:0] {
    IMM_I     = 3'd0,
    IMM_S     = 3'd1,
    IMM_B     = 3'd2,
    IMM_J     = 3'd3,
    IMM_U     = 3'd4,
    IMM_SHAMT = 3'd5,
    IMM_ZIMM  = 3'd6,
    IMM_RSVD  = 3'd7
  } imm_src_e;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Input/output handshake bundle of the immediate pipeline; slave is the
// pipeline side, master is the producer/consumer side.
interface imm_gen_pipe_if
  import imm_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) ();

  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] instr;
  imm_src_e           imm_src;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    imm_ext;
  logic [TAG_W-1:0]   out_tag;
  logic               illegal;

  modport slave (
    input  in_valid, instr, imm_src, in_tag, out_ready,
    output in_ready, out_valid, imm_ext, out_tag, illegal
  );

  modport master (
    output in_valid, instr, imm_src, in_tag, out_ready,
    input  in_ready, out_valid, imm_ext, out_tag, illegal
  );

endinterface

// File: rtl/imm_decode.sv
// Combinational immediate decoder: picks the immediate field of a RISC-V
// instruction by format and sign/zero-extends it to XLEN.
module imm_decode
  import imm_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic [INSTR_W-1:0] instr,
  input  imm_src_e           imm_src,
  output logic [XLEN-1:0]    imm,
  output logic               illegal
);

  logic signed [11:0] w_i;
  logic signed [11:0] w_s;
  logic signed [12:0] w_b;
  logic signed [20:0] w_j;
  logic signed [31:0] w_u;
  logic               w_unused_opcode;

  assign w_i = instr[31:20];
  assign w_s = {instr[31:25], instr[11:7]};
  assign w_b = {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign w_j = {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign w_u = {instr[31:12], 12'b0};

  // Opcode bits never contribute to the immediate.
  assign w_unused_opcode = ^instr[6:0];

  always_comb begin
    imm     = '0;
    illegal = 1'b0;
    case (imm_src)
      IMM_I:     imm = XLEN'(w_i);
      IMM_S:     imm = XLEN'(w_s);
      IMM_B:     imm = XLEN'(w_b);
      IMM_J:     imm = XLEN'(w_j);
      IMM_U:     imm = XLEN'(w_u);
      IMM_SHAMT: imm = (XLEN == 64) ? XLEN'(instr[25:20]) : XLEN'(instr[24:20]);
      IMM_ZIMM:  imm = XLEN'(instr[19:15]);
      IMM_RSVD:  illegal = 1'b1;
      default:   illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decode into slice 0, then STAGES valid/ready
// register slices carrying {valid, imm, tag, illegal} to the execute stage.
module imm_gen_pipe
  import imm_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned STAGES = 1,
  parameter int unsigned TAG_W  = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  imm_gen_pipe_if.slave bus
);

  typedef struct packed {
    logic             valid;
    logic [XLEN-1:0]  imm;
    logic [TAG_W-1:0] tag;
    logic             illegal;
  } slice_t;

  logic [XLEN-1:0]     w_dec_imm;
  logic                w_dec_illegal;
  slice_t              w_head;
  slice_t              w_tail;
  slice_t [STAGES-1:0] w_slices;
  logic   [STAGES:0]   w_ready;

  imm_decode #(.XLEN(XLEN)) u_decode (
    .instr   (bus.instr),
    .imm_src (bus.imm_src),
    .imm     (w_dec_imm),
    .illegal (w_dec_illegal)
  );

  assign w_head = '{valid: bus.in_valid, imm: w_dec_imm, tag: bus.in_tag, illegal: w_dec_illegal};

  // A slice can take new data when it is empty or its content moves on this edge.
  always_comb begin
    w_ready         = '0;
    w_ready[STAGES] = bus.out_ready;
    for (int i = int'(STAGES) - 1; i >= 0; i--) begin
      w_ready[i] = !w_slices[i].valid || w_ready[i+1];
    end
  end

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_slice
    slice_t r_slice;
    slice_t w_up;

    if (gi == 0) begin : g_head
      assign w_up = w_head;
    end else begin : g_link
      assign w_up = w_slices[gi-1];
    end

    assign w_slices[gi] = r_slice;

    always_ff @(posedge clk) begin
      if (reset) begin
        r_slice <= '0;
      end else if (flush) begin
        r_slice.valid <= 1'b0;
      end else if (w_ready[gi]) begin
        if (w_up.valid) begin
          r_slice <= w_up;
        end else begin
          r_slice.valid <= 1'b0;
        end
      end
    end
  end

  assign w_tail        = w_slices[STAGES-1];
  assign bus.in_ready  = w_ready[0] && !flush;
  assign bus.out_valid = w_tail.valid;
  assign bus.imm_ext   = w_tail.imm;
  assign bus.out_tag   = w_tail.tag;
  assign bus.illegal   = w_tail.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed bench for imm_gen_pipe: four instances cover XLEN 32/64 decode,
// backpressure, streaming latency, flush and reset.
module tb_imm_gen_pipe;
  import imm_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic flush_s1, flush_x64, flush_s2, flush_s3;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] v_instr [9];
  logic [2:0]  v_src   [9];
  logic [63:0] v_e32   [9];
  logic [63:0] v_e64   [9];
  logic        v_ill   [9];

  always #5 clk = ~clk;

  imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) bus_s1  ();
  imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) bus_x64 ();
  imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) bus_s2  ();
  imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) bus_s3  ();

  imm_gen_pipe #(.XLEN(32), .STAGES(1), .TAG_W(5)) u_s1 (
    .clk(clk), .reset(reset), .flush(flush_s1), .bus(bus_s1));
  imm_gen_pipe #(.XLEN(64), .STAGES(1), .TAG_W(5)) u_x64 (
    .clk(clk), .reset(reset), .flush(flush_x64), .bus(bus_x64));
  imm_gen_pipe #(.XLEN(32), .STAGES(2), .TAG_W(5)) u_s2 (
    .clk(clk), .reset(reset), .flush(flush_s2), .bus(bus_s2));
  imm_gen_pipe #(.XLEN(32), .STAGES(3), .TAG_W(5)) u_s3 (
    .clk(clk), .reset(reset), .flush(flush_s3), .bus(bus_s3));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] i_instr(input logic [11:0] imm);
    return {imm, 20'h00013};
  endfunction

  initial begin
    v_instr[0] = 32'hFFC4A303; v_src[0] = 3'b000; v_e32[0] = 64'hFFFFFFFC; v_e64[0] = 64'hFFFFFFFFFFFFFFFC; v_ill[0] = 1'b0;
    v_instr[1] = 32'h0064A423; v_src[1] = 3'b001; v_e32[1] = 64'h00000008; v_e64[1] = 64'h8;                v_ill[1] = 1'b0;
    v_instr[2] = 32'hFE420AE3; v_src[2] = 3'b010; v_e32[2] = 64'hFFFFFFF4; v_e64[2] = 64'hFFFFFFFFFFFFFFF4; v_ill[2] = 1'b0;
    v_instr[3] = 32'h0080006F; v_src[3] = 3'b011; v_e32[3] = 64'h00000008; v_e64[3] = 64'h8;                v_ill[3] = 1'b0;
    v_instr[4] = 32'hF0F0F037; v_src[4] = 3'b100; v_e32[4] = 64'hF0F0F000; v_e64[4] = 64'hFFFFFFFFF0F0F000; v_ill[4] = 1'b0;
    v_instr[5] = 32'h41F05013; v_src[5] = 3'b101; v_e32[5] = 64'h1F;       v_e64[5] = 64'h1F;               v_ill[5] = 1'b0;
    v_instr[6] = 32'h03F05013; v_src[6] = 3'b101; v_e32[6] = 64'h1F;       v_e64[6] = 64'h3F;               v_ill[6] = 1'b0;
    v_instr[7] = 32'h000A8073; v_src[7] = 3'b110; v_e32[7] = 64'h15;       v_e64[7] = 64'h15;               v_ill[7] = 1'b0;
    v_instr[8] = 32'hFFFFFFFF; v_src[8] = 3'b111; v_e32[8] = 64'h0;        v_e64[8] = 64'h0;                v_ill[8] = 1'b1;

    reset = 1'b1;
    flush_s1 = 1'b0; flush_x64 = 1'b0; flush_s2 = 1'b0; flush_s3 = 1'b0;
    bus_s1.in_valid  = 1'b0; bus_s1.instr  = '0; bus_s1.imm_src  = IMM_I; bus_s1.in_tag  = '0; bus_s1.out_ready  = 1'b1;
    bus_x64.in_valid = 1'b0; bus_x64.instr = '0; bus_x64.imm_src = IMM_I; bus_x64.in_tag = '0; bus_x64.out_ready = 1'b1;
    bus_s2.in_valid  = 1'b0; bus_s2.instr  = '0; bus_s2.imm_src  = IMM_I; bus_s2.in_tag  = '0; bus_s2.out_ready  = 1'b1;
    bus_s3.in_valid  = 1'b0; bus_s3.instr  = '0; bus_s3.imm_src  = IMM_I; bus_s3.in_tag  = '0; bus_s3.out_ready  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_s1_valid", 64'(bus_s1.out_valid), 64'd0);
    chk("rst_s1_imm", 64'(bus_s1.imm_ext), 64'd0);
    chk("rst_s1_ready", 64'(bus_s1.in_ready), 64'd1);
    chk("rst_x64_valid", 64'(bus_x64.out_valid), 64'd0);
    chk("rst_x64_imm", bus_x64.imm_ext, 64'd0);
    chk("rst_s2_valid", 64'(bus_s2.out_valid), 64'd0);
    chk("rst_s3_valid", 64'(bus_s3.out_valid), 64'd0);
    chk("rst_s3_ready", 64'(bus_s3.in_ready), 64'd1);

    // Decode table through the single-slice 32- and 64-bit instances.
    for (int k = 0; k < 9; k++) begin
      bus_s1.in_valid  = 1'b1; bus_s1.instr  = v_instr[k]; bus_s1.imm_src  = imm_src_e'(v_src[k]); bus_s1.in_tag  = 5'(k + 1);
      bus_x64.in_valid = 1'b1; bus_x64.instr = v_instr[k]; bus_x64.imm_src = imm_src_e'(v_src[k]); bus_x64.in_tag = 5'(k + 1);
      tick();
      chk($sformatf("s1_valid_%0d", k), 64'(bus_s1.out_valid), 64'd1);
      chk($sformatf("s1_imm_%0d", k), 64'(bus_s1.imm_ext), v_e32[k]);
      chk($sformatf("s1_tag_%0d", k), 64'(bus_s1.out_tag), 64'(k + 1));
      chk($sformatf("s1_ill_%0d", k), 64'(bus_s1.illegal), 64'(v_ill[k]));
      chk($sformatf("x64_imm_%0d", k), bus_x64.imm_ext, v_e64[k]);
      chk($sformatf("x64_ill_%0d", k), 64'(bus_x64.illegal), 64'(v_ill[k]));
    end
    bus_s1.in_valid  = 1'b0;
    bus_x64.in_valid = 1'b0;
    tick();
    chk("s1_drained", 64'(bus_s1.out_valid), 64'd0);
    chk("x64_drained", 64'(bus_x64.out_valid), 64'd0);

    // Three-slice stream: first result three edges after first accept, no gaps.
    for (int c = 0; c < 9; c++) begin
      if (c < 6) begin
        bus_s3.in_valid = 1'b1; bus_s3.instr = i_instr(12'(10 + c)); bus_s3.in_tag = 5'(10 + c);
      end else begin
        bus_s3.in_valid = 1'b0;
      end
      #1;
      chk($sformatf("s3_in_ready_%0d", c), 64'(bus_s3.in_ready), 64'd1);
      tick();
      if (c >= 2 && c < 8) begin
        chk($sformatf("s3_valid_%0d", c), 64'(bus_s3.out_valid), 64'd1);
        chk($sformatf("s3_tag_%0d", c), 64'(bus_s3.out_tag), 64'(10 + c - 2));
        chk($sformatf("s3_imm_%0d", c), 64'(bus_s3.imm_ext), 64'(10 + c - 2));
      end else begin
        chk($sformatf("s3_valid_%0d", c), 64'(bus_s3.out_valid), 64'd0);
      end
    end

    // Two-slice backpressure: fill, stall, then drain while accepting.
    bus_s2.out_ready = 1'b0;
    bus_s2.in_valid = 1'b1; bus_s2.imm_src = IMM_I; bus_s2.instr = i_instr(12'd1); bus_s2.in_tag = 5'd1;
    #1;
    chk("bp_ready_t1", 64'(bus_s2.in_ready), 64'd1);
    tick();
    bus_s2.instr = i_instr(12'd2); bus_s2.in_tag = 5'd2;
    #1;
    chk("bp_ready_t2", 64'(bus_s2.in_ready), 64'd1);
    tick();
    bus_s2.instr = i_instr(12'd3); bus_s2.in_tag = 5'd3;
    #1;
    chk("bp_ready_t3", 64'(bus_s2.in_ready), 64'd0);
    chk("bp_valid_stall", 64'(bus_s2.out_valid), 64'd1);
    chk("bp_tag_stall", 64'(bus_s2.out_tag), 64'd1);
    tick();
    chk("bp_tag_held", 64'(bus_s2.out_tag), 64'd1);
    chk("bp_imm_held", 64'(bus_s2.imm_ext), 64'd1);
    chk("bp_ready_held", 64'(bus_s2.in_ready), 64'd0);
    bus_s2.out_ready = 1'b1;
    #1;
    chk("bp_ready_drain", 64'(bus_s2.in_ready), 64'd1);
    tick();
    bus_s2.in_valid = 1'b0;
    chk("bp_tag_2", 64'(bus_s2.out_tag), 64'd2);
    chk("bp_valid_2", 64'(bus_s2.out_valid), 64'd1);
    tick();
    chk("bp_tag_3", 64'(bus_s2.out_tag), 64'd3);
    chk("bp_imm_3", 64'(bus_s2.imm_ext), 64'd3);
    tick();
    chk("bp_empty", 64'(bus_s2.out_valid), 64'd0);

    // Flush with two entries in flight and a competing input.
    bus_s2.out_ready = 1'b0;
    bus_s2.in_valid = 1'b1; bus_s2.instr = i_instr(12'd4); bus_s2.in_tag = 5'd4;
    tick();
    bus_s2.instr = i_instr(12'd5); bus_s2.in_tag = 5'd5;
    tick();
    bus_s2.out_ready = 1'b1; flush_s2 = 1'b1;
    bus_s2.instr = i_instr(12'd6); bus_s2.in_tag = 5'd6;
    #1;
    chk("fl_in_ready", 64'(bus_s2.in_ready), 64'd0);
    chk("fl_out_tag", 64'(bus_s2.out_tag), 64'd4);
    tick();
    flush_s2 = 1'b0; bus_s2.in_valid = 1'b0;
    chk("fl_valid_next", 64'(bus_s2.out_valid), 64'd0);
    tick();
    chk("fl_valid_2", 64'(bus_s2.out_valid), 64'd0);
    tick();
    chk("fl_valid_3", 64'(bus_s2.out_valid), 64'd0);

    // Reset with full pipelines and the consumer stalled.
    bus_s2.out_ready = 1'b0;
    bus_s1.out_ready = 1'b0;
    bus_s2.in_valid = 1'b1; bus_s2.instr = i_instr(12'h7FF); bus_s2.in_tag = 5'd7;
    bus_s1.in_valid = 1'b1; bus_s1.instr = 32'h0; bus_s1.imm_src = IMM_RSVD; bus_s1.in_tag = 5'd9;
    tick();
    bus_s1.in_valid = 1'b0;
    bus_s2.imm_src = IMM_RSVD; bus_s2.in_tag = 5'd8;
    tick();
    bus_s2.in_valid = 1'b0;
    chk("pre_s2_ready", 64'(bus_s2.in_ready), 64'd0);
    chk("pre_s2_imm", 64'(bus_s2.imm_ext), 64'h7FF);
    chk("pre_s1_ill", 64'(bus_s1.illegal), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mr_s2_valid", 64'(bus_s2.out_valid), 64'd0);
    chk("mr_s2_imm", 64'(bus_s2.imm_ext), 64'd0);
    chk("mr_s2_tag", 64'(bus_s2.out_tag), 64'd0);
    chk("mr_s2_ill", 64'(bus_s2.illegal), 64'd0);
    chk("mr_s2_ready", 64'(bus_s2.in_ready), 64'd1);
    chk("mr_s1_valid", 64'(bus_s1.out_valid), 64'd0);
    chk("mr_s1_ill", 64'(bus_s1.illegal), 64'd0);
    chk("mr_s1_tag", 64'(bus_s1.out_tag), 64'd0);
    chk("mr_s1_ready", 64'(bus_s1.in_ready), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
